vehicle_detector: RTL and testbench
===================================

VEHICLE_DETECTOR -- requirements
Module: vehicle_detector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized-high cycles needed to qualify a vehicle (legal range 2..15).
REQ-002 Parameter HOLD_CYCLES, default 8: cycles the request is held after the vehicle leaves (legal range 1..255).
REQ-003 Parameter STUCK_CYCLES, default 200: continuous-presence cycles that declare a sensor fault (legal range 2..1023).
REQ-004 Parameter COUNT_W, default 8: width of the vehicle counter.
REQ-005 Port CLOCK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 Port CLEAR, input, 1 bit: synchronous, active-high reset.
REQ-007 Port SENSOR_RAW, input, 1 bit: asynchronous road-loop detector level; high means metal is over the loop.
REQ-008 Port COUNTRY_SIG, input, 2 bits: country-road light state fed back from signal_control.
REQ-009 Port VEHICLE_ON_COUNTRY_ROAD, output, 1 bit: registered request to signal_control.
REQ-010 Port VEHICLE_COUNT, output, COUNT_W bits: number of qualified vehicles; saturates at all-ones.
REQ-011 Port SENSOR_FAULT, output, 1 bit: registered; high while the detector is in FAULT.

Function
REQ-012 SENSOR_RAW SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the second-flop output, sensor_s.
REQ-013 FSM states SHALL be IDLE, QUALIFY, PRESENT, HOLD and FAULT.
REQ-014 IDLE transitions:
- sensor_s=1 -> QUALIFY, debounce count = 1.
- otherwise stay in IDLE.
REQ-015 QUALIFY transitions:
- sensor_s=0 -> IDLE, no count change.
- sensor_s=1 and debounce count = DEBOUNCE_CYCLES-1 -> PRESENT, VEHICLE_COUNT +1 (saturating).
- otherwise increment the debounce count.
REQ-016 PRESENT transitions:
- sensor_s=0 -> HOLD, hold count = HOLD_CYCLES-1.
- presence count reaching STUCK_CYCLES-1 -> FAULT.
- otherwise increment the presence count.
REQ-017 HOLD transitions, in priority order:
- sensor_s=1 -> PRESENT, presence count = 0, no increment of VEHICLE_COUNT.
- COUNTRY_SIG = GREEN -> IDLE (vehicle served).
- hold count = 0 -> IDLE.
- otherwise decrement the hold count.
REQ-018 FAULT transitions:
- sensor_s=0 -> IDLE.
- otherwise stay in FAULT.
REQ-019 VEHICLE_ON_COUNTRY_ROAD SHALL be 1 exactly when the registered state is PRESENT, HOLD or FAULT (fail-safe: a stuck sensor keeps serving the country road).
REQ-020 Latency: if SENSOR_RAW is first sampled high at edge N and stays high, VEHICLE_ON_COUNTRY_ROAD SHALL rise after edge N+1+DEBOUNCE_CYCLES.
REQ-021 Any high pulse on sensor_s shorter than DEBOUNCE_CYCLES cycles SHALL NOT assert VEHICLE_ON_COUNTRY_ROAD or change VEHICLE_COUNT.
REQ-022 Once VEHICLE_COUNT is all-ones, further qualifications SHALL leave it unchanged.
REQ-023 COUNTRY_SIG values other than GREEN SHALL influence only the HOLD-state decision; COUNTRY_SIG is ignored in all other states.

Reset
REQ-024 On CLEAR=1 at a rising edge, the block SHALL reset to:
- state IDLE;
- synchronizer flops and all internal counters 0;
- VEHICLE_ON_COUNTRY_ROAD, VEHICLE_COUNT and SENSOR_FAULT all 0.
REQ-025 CLEAR SHALL override every transition, including mid-QUALIFY, HOLD and FAULT.
REQ-026 Normal operation SHALL resume on the first edge with CLEAR=0.

Structure
REQ-027 Shared package sig_ctrl_pkg SHALL hold the light encoding RED=2'd0, YELLOW=2'd1, GREEN=2'd2 (also used by signal_control) and the detector state encoding.
REQ-028 The synchronizer SHALL be a separate sub-module, sensor_sync (2 flops, reset by CLEAR); everything else is flat in vehicle_detector.

Verification
REQ-029 The bench SHALL run with default parameters and cover these directed scenarios:
- CLEAR held 5 cycles, then SENSOR_RAW high from edge 10 -> all outputs 0 during CLEAR; VEHICLE_ON_COUNTRY_ROAD rises after edge 15; VEHICLE_COUNT = 1.
- 3-cycle SENSOR_RAW pulse -> VEHICLE_ON_COUNTRY_ROAD stays 0 and VEHICLE_COUNT stays 0.
- Vehicle leaves with COUNTRY_SIG = RED -> request held exactly 8 cycles, then drops; re-entry during HOLD returns to PRESENT with VEHICLE_COUNT unchanged.
- In HOLD, COUNTRY_SIG = GREEN -> VEHICLE_ON_COUNTRY_ROAD drops after the next edge.
- SENSOR_RAW high 250 cycles -> SENSOR_FAULT = 1 with request still 1; SENSOR_RAW low -> both return to 0 three edges later.
- 260 qualified vehicles -> VEHICLE_COUNT = 255; CLEAR asserted mid-QUALIFY -> everything returns to 0 on that edge.

Source files
------------

// File: rtl/sig_ctrl_pkg.sv
// Types shared by the country-road signal controller and the vehicle detector:
// light encoding and detector state encoding.
package sig_ctrl_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUALIFY = 3'd1,
        PRESENT = 3'd2,
        HOLD    = 3'd3,
        FAULT   = 3'd4
    } det_state_t;

endpackage

// File: rtl/vehicle_detector_sensor_sync.sv
// Two-flop synchronizer for the asynchronous road-loop level.
module sensor_sync (
    input  logic clk,
    input  logic clear,
    input  logic async_in,
    output logic sync_out
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sync_out = sync2_q;

endmodule

// File: rtl/vehicle_detector.sv
// Country-road vehicle detector: debounces the loop sensor, counts vehicles,
// holds the request after departure and flags a stuck sensor.
module vehicle_detector
    import sig_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int STUCK_CYCLES    = 200,
    parameter int COUNT_W         = 8
) (
    input  logic               CLOCK,
    input  logic               CLEAR,
    input  logic               SENSOR_RAW,
    input  logic [1:0]         COUNTRY_SIG,
    output logic               VEHICLE_ON_COUNTRY_ROAD,
    output logic [COUNT_W-1:0] VEHICLE_COUNT,
    output logic               SENSOR_FAULT,
    output det_state_t         dbg_state
);

    localparam logic [3:0]         DEB_LAST  = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]         HOLD_INIT = 8'(HOLD_CYCLES - 1);
    localparam logic [9:0]         PRES_LAST = 10'(STUCK_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic sensor_s;

    det_state_t         state_q, state_d;
    logic [3:0]         deb_q, deb_d;
    logic [7:0]         hold_q, hold_d;
    logic [9:0]         pres_q, pres_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               req_q, req_d;
    logic               fault_q, fault_d;

    sensor_sync u_sync (
        .clk      (CLOCK),
        .clear    (CLEAR),
        .async_in (SENSOR_RAW),
        .sync_out (sensor_s)
    );

    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        hold_d  = hold_q;
        pres_d  = pres_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (sensor_s) begin
                    state_d = QUALIFY;
                    deb_d   = 4'd1;
                end
            end
            QUALIFY: begin
                if (!sensor_s) begin
                    state_d = IDLE;
                    deb_d   = 4'd0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = PRESENT;
                    pres_d  = 10'd0;
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + COUNT_W'(1);
                    end
                end else begin
                    deb_d = deb_q + 4'd1;
                end
            end
            PRESENT: begin
                if (!sensor_s) begin
                    state_d = HOLD;
                    hold_d  = HOLD_INIT;
                end else if (pres_q == PRES_LAST) begin
                    state_d = FAULT;
                end else begin
                    pres_d = pres_q + 10'd1;
                end
            end
            HOLD: begin
                // Re-entry is the same vehicle, so it is not counted again.
                if (sensor_s) begin
                    state_d = PRESENT;
                    pres_d  = 10'd0;
                end else if (light_t'(COUNTRY_SIG) == GREEN) begin
                    state_d = IDLE;
                end else if (hold_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            FAULT: begin
                if (!sensor_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A stuck sensor keeps requesting so the country road is never starved.
        req_d   = (state_d == PRESENT) || (state_d == HOLD) || (state_d == FAULT);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge CLOCK) begin
        if (CLEAR) begin
            state_q <= IDLE;
            deb_q   <= '0;
            hold_q  <= '0;
            pres_q  <= '0;
            count_q <= '0;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            hold_q  <= hold_d;
            pres_q  <= pres_d;
            count_q <= count_d;
            req_q   <= req_d;
            fault_q <= fault_d;
        end
    end

    assign VEHICLE_ON_COUNTRY_ROAD = req_q;
    assign VEHICLE_COUNT           = count_q;
    assign SENSOR_FAULT            = fault_q;
    assign dbg_state               = state_q;

endmodule

// File: tb/tb_vehicle_detector.sv
// Bench for vehicle_detector: directed scenarios plus randomized traffic,
// scored every cycle against a timing-level model of the detector rules.
module tb_vehicle_detector;
    import sig_ctrl_pkg::*;

    localparam int D    = 4;
    localparam int H    = 8;
    localparam int S    = 200;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          clear = 1'b1;
    logic          raw = 1'b0;
    logic [1:0]    csig = 2'd0;
    logic          req;
    logic [CW-1:0] cnt;
    logic          flt;
    det_state_t    dbg;

    vehicle_detector #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .STUCK_CYCLES    (S),
        .COUNT_W         (CW)
    ) dut (
        .CLOCK                   (clk),
        .CLEAR                   (clear),
        .SENSOR_RAW              (raw),
        .COUNTRY_SIG             (csig),
        .VEHICLE_ON_COUNTRY_ROAD (req),
        .VEHICLE_COUNT           (cnt),
        .SENSOR_FAULT            (flt),
        .dbg_state               (dbg)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [CW+1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: the detector's rules expressed as durations
    // (consecutive-high run, time since leaving, dwell while served).
    bit m_d1, m_d2;
    int m_run, m_gap, m_dwell, m_count;
    bit m_serving, m_faulted;

    function automatic void model_step(input bit clr, input bit r, input logic [1:0] c);
        bit s;
        if (clr) begin
            m_d1 = 0; m_d2 = 0; m_run = 0; m_gap = 0; m_dwell = 0; m_count = 0;
            m_serving = 0; m_faulted = 0;
            return;
        end
        s    = m_d2;
        m_d2 = m_d1;
        m_d1 = r;
        m_run = s ? m_run + 1 : 0;
        if (m_faulted) begin
            if (!s) begin
                m_faulted = 0;
                m_serving = 0;
            end
        end else if (m_serving) begin
            if (s) begin
                if (m_gap > 0) begin
                    m_gap   = 0;
                    m_dwell = 1;
                end else begin
                    m_dwell++;
                    if (m_dwell == S + 1) m_faulted = 1;
                end
            end else begin
                m_gap++;
                if ((m_gap > 1 && c == GREEN) || m_gap == H + 1) begin
                    m_serving = 0;
                    m_gap     = 0;
                end
            end
        end else if (m_run == D) begin
            m_serving = 1;
            m_dwell   = 1;
            m_gap     = 0;
            if (m_count < CMAX) m_count++;
        end
    endfunction

    // Driver: one rising edge per call, expected outputs queued for the monitor.
    task automatic cycle(input bit r, input logic [1:0] c, input bit clr);
        @(negedge clk);
        raw   = r;
        csig  = c;
        clear = clr;
        @(posedge clk);
        cyc++;
        model_step(clr, r, c);
        exp_q.push_back({1'(m_serving || m_faulted), 1'(m_faulted), CW'(m_count)});
    endtask

    // Monitor / scoreboard
    initial begin
        logic [CW+1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("req", 32'(req), 32'(e[CW+1]));
                chk("fault", 32'(flt), 32'(e[CW]));
                chk("count", 32'(cnt), 32'(e[CW-1:0]));
            end
        end
    end

    initial begin
        #2ms;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_hi, n_lo;
        logic [1:0] c;

        // Reset held 5 edges, then a vehicle arrives at edge 10.
        for (int e = 1; e <= 5; e++) begin
            cycle(1'b0, RED, 1'b1);
            #1;
            chk("clear_req", 32'(req), 32'd0);
        end
        for (int e = 6; e <= 9; e++) cycle(1'b0, RED, 1'b0);
        for (int e = 10; e <= 20; e++) begin
            cycle(1'b1, RED, 1'b0);
            #1;
            if (e == 14) chk("latency_before", 32'(req), 32'd0);
            if (e == 15) begin
                chk("latency_rise", 32'(req), 32'd1);
                chk("first_count", 32'(cnt), 32'd1);
            end
        end

        // Leaves under RED: hold spans edges 23..30.
        for (int e = 21; e <= 33; e++) begin
            cycle(1'b0, RED, 1'b0);
            #1;
            chk("hold_window", 32'(req), (e <= 30) ? 32'd1 : 32'd0);
        end

        // Second vehicle, then re-entry during HOLD.
        for (int e = 34; e <= 45; e++) cycle(1'b1, RED, 1'b0);
        for (int e = 46; e <= 49; e++) cycle(1'b0, YELLOW, 1'b0);
        for (int e = 50; e <= 55; e++) begin
            cycle(1'b1, RED, 1'b0);
            #1;
            chk("reentry_req", 32'(req), 32'd1);
        end
        chk("reentry_count", 32'(cnt), 32'd2);

        // GREEN during HOLD ends the request one edge after HOLD is entered.
        for (int e = 56; e <= 60; e++) begin
            cycle(1'b0, GREEN, 1'b0);
            #1;
            chk("green_drop", 32'(req), (e <= 58) ? 32'd1 : 32'd0);
        end

        // 3-cycle glitch must not qualify.
        for (int e = 61; e <= 63; e++) cycle(1'b1, RED, 1'b0);
        for (int e = 64; e <= 75; e++) begin
            cycle(1'b0, RED, 1'b0);
            #1;
            chk("glitch_req", 32'(req), 32'd0);
        end
        chk("glitch_count", 32'(cnt), 32'd2);

        // Stuck sensor.
        for (int e = 76; e <= 325; e++) cycle(1'b1, RED, 1'b0);
        #1;
        chk("stuck_fault", 32'(flt), 32'd1);
        chk("stuck_req", 32'(req), 32'd1);
        for (int e = 326; e <= 329; e++) begin
            cycle(1'b0, RED, 1'b0);
            #1;
            chk("fault_exit", 32'(flt), (e <= 327) ? 32'd1 : 32'd0);
            chk("fault_exit_req", 32'(req), (e <= 327) ? 32'd1 : 32'd0);
        end

        // 260 qualifying vehicles saturate the counter.
        for (int v = 0; v < 260; v++) begin
            n_hi = $urandom_range(8, 4);
            n_lo = $urandom_range(14, 10);
            for (int i = 0; i < n_hi; i++) begin
                c = 2'($urandom_range(2, 0));
                cycle(1'b1, c, 1'b0);
            end
            for (int i = 0; i < n_lo; i++) begin
                c = 2'($urandom_range(2, 0));
                cycle(1'b0, c, 1'b0);
            end
        end
        #1;
        chk("saturated", 32'(cnt), 32'(CMAX));

        // CLEAR in the middle of QUALIFY.
        for (int i = 0; i < 4; i++) cycle(1'b1, RED, 1'b0);
        cycle(1'b1, RED, 1'b1);
        #1;
        chk("midq_count", 32'(cnt), 32'd0);
        chk("midq_req", 32'(req), 32'd0);
        chk("midq_fault", 32'(flt), 32'd0);

        // Random traffic with occasional long stalls and clears.
        for (int k = 0; k < 300; k++) begin
            n_hi = ($urandom_range(19, 0) == 0) ? $urandom_range(230, 205) : $urandom_range(12, 1);
            n_lo = $urandom_range(14, 1);
            for (int i = 0; i < n_hi; i++) begin
                c = 2'($urandom_range(3, 0));
                cycle(1'b1, c, ($urandom_range(99, 0) == 0));
            end
            for (int i = 0; i < n_lo; i++) begin
                c = 2'($urandom_range(3, 0));
                cycle(1'b0, c, ($urandom_range(99, 0) == 0));
            end
        end

        for (int i = 0; i < 4; i++) cycle(1'b0, RED, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
